// File: rtl/falafel_lsu_arbiter.sv
// Purpose: serialises header LSU operations from NUM_REQ requesters and honours the free-list lock.
// Latency: grant -> lsu_req_o.val next cycle; rsp_o pulse one cycle after lsu_rsp_i.val; next grant one cycle later.
// Backpressure: one operation in flight; lsu_req_o held stable until lsu_req_rdy_i; requesters wait on req_rdy_o.

package falafel_lsu_pkg;

  typedef enum logic [2:0] {
    LSU_LOAD                    = 3'd0,
    LSU_EDIT_SIZE_AND_NEXT_ADDR = 3'd1,
    LSU_EDIT_NEXT_ADDR          = 3'd2,
    LSU_LOCK                    = 3'd3,
    LSU_UNLOCK                  = 3'd4
  } lsu_op_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] size;
    logic [63:0] next_addr;
  } header_t;

  typedef struct packed {
    logic    val;
    lsu_op_t lsu_op;
    header_t header;
  } header_req_t;

  typedef struct packed {
    logic    val;
    header_t header;
  } header_rsp_t;

endpackage

module falafel_lsu_arbiter
  import falafel_lsu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  header_req_t       req_i     [NUM_REQ],
  output logic              req_rdy_o [NUM_REQ],
  output header_rsp_t       rsp_o     [NUM_REQ],
  output header_req_t       lsu_req_o,
  input  logic              lsu_req_rdy_i,
  input  header_rsp_t       lsu_rsp_i,
  output logic              lock_held_o,
  output logic [IDX_W-1:0]  lock_owner_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  lsu_op_t          cur_op_q;
  header_t          cur_hdr_q;
  logic [IDX_W-1:0] cur_idx_q;
  header_t          rsp_hdr_q;
  logic             lock_held_q;
  logic [IDX_W-1:0] lock_owner_q;
  logic [IDX_W-1:0] rr_ptr_q;
  // Set during reset so the cycle right after reset also issues no grant.
  logic             rst_d_q;

  logic [NUM_REQ-1:0] cand;
  logic               gnt_vld;
  logic [IDX_W-1:0]   gnt_idx;
  logic               grant;
  logic               rsp_take;

  // Candidate set: every valid requester, or only the lock owner while the lock is held.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand[i] = req_i[i].val && (!lock_held_q || (lock_owner_q == IDX_W'(i)));
    end
  end

  // Round-robin scan: first candidate at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_vld && cand[IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign grant    = (state_q == IDLE) && gnt_vld && !rst_i && !rst_d_q;
  assign rsp_take = (state_q == WAIT_RSP) && lsu_rsp_i.val;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and all handshake outputs; strobes are forced low while reset is asserted.
  always_comb begin
    state_d   = state_q;
    lsu_req_o = '{val: 1'b0, lsu_op: cur_op_q, header: cur_hdr_q};
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rdy_o[i]    = grant && (gnt_idx == IDX_W'(i));
      rsp_o[i].val    = (state_q == RESP) && !rst_i && (cur_idx_q == IDX_W'(i));
      rsp_o[i].header = rsp_hdr_q;
    end
    case (state_q)
      IDLE: begin
        if (grant) state_d = ISSUE;
      end
      ISSUE: begin
        lsu_req_o.val = !rst_i;
        if (lsu_req_rdy_i) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (lsu_rsp_i.val) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the granted request, advance rr_ptr when unlocked, capture response and update the lock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_op_q     <= LSU_LOAD;
      cur_hdr_q    <= '0;
      cur_idx_q    <= '0;
      rsp_hdr_q    <= '0;
      lock_held_q  <= 1'b0;
      lock_owner_q <= '0;
      rr_ptr_q     <= '0;
      rst_d_q      <= 1'b1;
    end else begin
      rst_d_q <= 1'b0;
      if (grant) begin
        cur_op_q  <= req_i[gnt_idx].lsu_op;
        cur_hdr_q <= req_i[gnt_idx].header;
        cur_idx_q <= gnt_idx;
        if (!lock_held_q) begin
          rr_ptr_q <= IDX_W'((int'(gnt_idx) + 1) % NUM_REQ);
        end
      end
      if (rsp_take) begin
        rsp_hdr_q <= lsu_rsp_i.header;
        if (cur_op_q == LSU_LOCK) begin
          lock_held_q  <= 1'b1;
          lock_owner_q <= cur_idx_q;
        end else if (cur_op_q == LSU_UNLOCK) begin
          lock_held_q  <= 1'b0;
        end
      end
    end
  end

  assign lock_held_o  = lock_held_q;
  assign lock_owner_o = lock_owner_q;

endmodule

// File: tb/tb_falafel_lsu_arbiter.sv
// Bench for falafel_lsu_arbiter: directed requester/LSU traffic against a transaction-level model.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
// The LSU model echoes each accepted header back after a programmable latency.

module tb_falafel_lsu_arbiter;
  import falafel_lsu_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int IDX_W   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i;
  header_req_t      req_i   [NUM_REQ];
  logic             req_rdy [NUM_REQ];
  header_rsp_t      rsp     [NUM_REQ];
  header_req_t      lsu_req;
  logic             lsu_req_rdy;
  header_rsp_t      lsu_rsp;
  logic             lock_held;
  logic [IDX_W-1:0] lock_owner;

  falafel_lsu_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .req_rdy_o    (req_rdy),
    .rsp_o        (rsp),
    .lsu_req_o    (lsu_req),
    .lsu_req_rdy_i(lsu_req_rdy),
    .lsu_rsp_i    (lsu_rsp),
    .lock_held_o  (lock_held),
    .lock_owner_o (lock_owner)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment state shared by driver, monitor and sequencer.
  int          cyc = 0;
  header_req_t rq [NUM_REQ][$];
  logic        acc [NUM_REQ];
  typedef struct { int at; header_t hdr; } sched_t;
  sched_t      sched[$];
  int          lsu_lat = 1;
  int          rdy_block_until = 0;

  typedef struct { int cyc; int idx; } gnt_t;
  typedef struct { int cyc; int idx; header_t hdr; } rsp_ev_t;
  gnt_t        gnt_log[$];
  rsp_ev_t     rsp_log[$];
  int          hs_count = 0;
  int          hs_cyc_last = 0;
  header_t     hs_hdr_last;

  // Transaction-level model.
  logic        m_lock = 1'b0;
  int          m_owner = 0;
  int          m_rr = 0;
  logic        m_busy = 1'b0;
  int          m_idx = 0;
  header_req_t m_req;
  logic        m_hs = 1'b0;
  int          m_hs_cyc = 0;
  int          m_issue_from = 0;
  int          m_rsp_due = -1;
  header_t     m_rsp_hdr;
  int          m_free_at = 0;

  function automatic header_req_t mk(input lsu_op_t op, input logic [63:0] a,
                                     input logic [63:0] s, input logic [63:0] n);
    header_req_t r;
    r.val = 1'b1;
    r.lsu_op = op;
    r.header.addr = a;
    r.header.size = s;
    r.header.next_addr = n;
    return r;
  endfunction

  // Driver: requester queues present their head; LSU returns scheduled responses.
  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_i[i] = '0;
      acc[i] = 1'b0;
    end
    lsu_rsp = '0;
    lsu_req_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i] && rq[i].size() > 0) rq[i].delete(0);
        acc[i] = 1'b0;
        if (rq[i].size() > 0) req_i[i] = rq[i][0];
        else req_i[i] = '0;
      end
      lsu_rsp = '0;
      if (sched.size() > 0 && sched[0].at <= cyc) begin
        lsu_rsp.val = 1'b1;
        lsu_rsp.header = sched[0].hdr;
        sched.delete(0);
      end
      lsu_req_rdy = (cyc >= rdy_block_until);
    end
  end

  // Monitor/compare: every cycle, DUT outputs against the model.
  int      cg;
  logic    c_exp_v;
  logic    c_lock_next;
  int      c_owner_next;
  int      c_j;
  sched_t  c_s;
  gnt_t    c_g;
  rsp_ev_t c_r;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_i) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          check("rst_req_rdy", req_rdy[i], 1'b0);
          check("rst_rsp_val", rsp[i].val, 1'b0);
          acc[i] = 1'b0;
        end
        check("rst_lsu_val", lsu_req.val, 1'b0);
        m_lock = 1'b0; m_owner = 0; m_rr = 0; m_busy = 1'b0; m_hs = 1'b0;
        m_rsp_due = -1; m_free_at = cyc + 2;
      end else begin
        cg = -1;
        if (!m_busy && cyc >= m_free_at) begin
          for (int k = 0; k < NUM_REQ; k++) begin
            c_j = (m_rr + k) % NUM_REQ;
            if (cg < 0 && req_i[c_j].val && (!m_lock || m_owner == c_j)) cg = c_j;
          end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          check("grant_rdy", req_rdy[i], (i == cg));
          acc[i] = req_rdy[i] && req_i[i].val;
          if (acc[i]) begin
            c_g.cyc = cyc; c_g.idx = i;
            gnt_log.push_back(c_g);
          end
        end
        if (cg >= 0) begin
          m_busy = 1'b1; m_idx = cg; m_req = req_i[cg]; m_hs = 1'b0;
          m_issue_from = cyc + 1; m_rsp_due = -1;
          if (!m_lock) m_rr = (cg + 1) % NUM_REQ;
        end
        c_exp_v = m_busy && !m_hs && (cyc >= m_issue_from);
        check("lsu_val", lsu_req.val, c_exp_v);
        if (c_exp_v) begin
          check("lsu_op", lsu_req.lsu_op, m_req.lsu_op);
          check("lsu_hdr", lsu_req.header, m_req.header);
        end
        if (lsu_req.val && lsu_req_rdy) begin
          hs_count++; hs_cyc_last = cyc; hs_hdr_last = lsu_req.header;
          c_s.at = cyc + lsu_lat; c_s.hdr = lsu_req.header;
          sched.push_back(c_s);
          if (c_exp_v) begin m_hs = 1'b1; m_hs_cyc = cyc; end
        end
        c_lock_next = m_lock; c_owner_next = m_owner;
        if (m_busy && m_hs && m_rsp_due < 0 && lsu_rsp.val && cyc > m_hs_cyc) begin
          m_rsp_due = cyc + 1; m_rsp_hdr = lsu_rsp.header;
          if (m_req.lsu_op == LSU_LOCK) begin c_lock_next = 1'b1; c_owner_next = m_idx; end
          else if (m_req.lsu_op == LSU_UNLOCK) c_lock_next = 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          c_exp_v = m_busy && (cyc == m_rsp_due) && (i == m_idx);
          check("rsp_val", rsp[i].val, c_exp_v);
          if (c_exp_v) check("rsp_hdr", rsp[i].header, m_rsp_hdr);
          if (rsp[i].val) begin
            c_r.cyc = cyc; c_r.idx = i; c_r.hdr = rsp[i].header;
            rsp_log.push_back(c_r);
          end
        end
        if (m_busy && cyc == m_rsp_due) begin
          m_busy = 1'b0; m_free_at = cyc + 1;
        end
        check("lock_held", lock_held, m_lock);
        if (m_lock) check("lock_owner", lock_owner, m_owner);
        m_lock = c_lock_next; m_owner = c_owner_next;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while ((rq[0].size() > 0 || rq[1].size() > 0 || m_busy || sched.size() > 0) && k < budget) begin
      step(1);
      k++;
    end
    check({name, "_done"}, (k < budget), 1'b1);
    step(2);
  endtask

  int g0, r0, h0, c0, k;
  int rr_seq [4] = '{0, 1, 0, 1};
  int lk_seq [5] = '{0, 0, 0, 0, 1};

  // Directed sequence with literal expectations.
  initial begin
    rst_i = 1'b1;
    step(3);
    rst_i = 1'b0;

    // Idle after reset.
    step(10);
    check("idle_grants", gnt_log.size(), 0);
    check("idle_lock_held", lock_held, 1'b0);
    check("idle_lsu_val", lsu_req.val, 1'b0);

    // Round robin with continuous LOADs.
    g0 = gnt_log.size(); r0 = rsp_log.size();
    for (int n = 0; n < 2; n++) begin
      rq[0].push_back(mk(LSU_LOAD, 64'h100, 64'h8, 64'h0));
      rq[1].push_back(mk(LSU_LOAD, 64'h200, 64'h8, 64'h0));
    end
    wait_idle("rr", 60);
    check("rr_count", gnt_log.size() - g0, 4);
    for (int n = 0; n < 4 && g0 + n < gnt_log.size(); n++) begin
      check("rr_order", gnt_log[g0 + n].idx, rr_seq[n]);
      if (n > 0) check("rr_spacing", gnt_log[g0 + n].cyc - gnt_log[g0 + n - 1].cyc, 4);
    end
    for (int n = r0; n < rsp_log.size(); n++) begin
      check("rr_rsp_addr", rsp_log[n].hdr.addr, (rsp_log[n].idx == 0) ? 64'h100 : 64'h200);
    end

    // Lock exclusion.
    g0 = gnt_log.size(); r0 = rsp_log.size();
    rq[0].push_back(mk(LSU_LOCK, 64'h10, 64'h0, 64'h0));
    rq[0].push_back(mk(LSU_LOAD, 64'h20, 64'h0, 64'h0));
    rq[0].push_back(mk(LSU_EDIT_NEXT_ADDR, 64'h30, 64'h0, 64'h33));
    rq[0].push_back(mk(LSU_UNLOCK, 64'h40, 64'h0, 64'h0));
    rq[1].push_back(mk(LSU_LOAD, 64'h500, 64'h0, 64'h0));
    k = 0;
    while (!lock_held && k < 30) begin step(1); k++; end
    check("lock_taken", lock_held, 1'b1);
    check("lock_owner0", lock_owner, 1'b0);
    wait_idle("lock", 80);
    check("lock_count", gnt_log.size() - g0, 5);
    for (int n = 0; n < 5 && g0 + n < gnt_log.size(); n++) begin
      check("lock_order", gnt_log[g0 + n].idx, lk_seq[n]);
    end
    if (gnt_log.size() >= g0 + 5 && rsp_log.size() >= r0 + 4) begin
      check("unlock_rsp_idx", rsp_log[r0 + 3].idx, 0);
      check("unlock_rsp_addr", rsp_log[r0 + 3].hdr.addr, 64'h40);
      check("req1_after_unlock", gnt_log[g0 + 4].cyc, rsp_log[r0 + 3].cyc + 1);
    end
    check("lock_released", lock_held, 1'b0);

    // LSU backpressure.
    g0 = gnt_log.size(); h0 = hs_count;
    rq[0].push_back(mk(LSU_EDIT_SIZE_AND_NEXT_ADDR, 64'h600, 64'h40, 64'h300));
    rdy_block_until = cyc + 7;
    wait_idle("bp", 40);
    check("bp_handshakes", hs_count - h0, 1);
    if (gnt_log.size() > g0) check("bp_stall", hs_cyc_last - gnt_log[g0].cyc, 6);
    check("bp_size", hs_hdr_last.size, 64'h40);
    check("bp_next_addr", hs_hdr_last.next_addr, 64'h300);

    // Stray UNLOCK.
    r0 = rsp_log.size();
    rq[1].push_back(mk(LSU_UNLOCK, 64'h700, 64'h0, 64'h0));
    wait_idle("stray", 30);
    check("stray_rsp_count", rsp_log.size() - r0, 1);
    if (rsp_log.size() > r0) check("stray_rsp_idx", rsp_log[r0].idx, 1);
    check("stray_lock_held", lock_held, 1'b0);

    // Reset during WAIT_RSP while locked; stale response must vanish.
    rq[0].push_back(mk(LSU_LOCK, 64'h800, 64'h0, 64'h0));
    wait_idle("relock", 30);
    check("relock_held", lock_held, 1'b1);
    lsu_lat = 8;
    rq[0].push_back(mk(LSU_LOAD, 64'h900, 64'h0, 64'h0));
    k = 0;
    while (!(m_busy && m_hs) && k < 20) begin step(1); k++; end
    check("mid_wait_reached", (k < 20), 1'b1);
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    r0 = rsp_log.size();
    c0 = cyc;
    step(10);
    check("stale_delivered", sched.size(), 0);
    check("stale_no_rsp", rsp_log.size() - r0, 0);
    check("post_rst_lock", lock_held, 1'b0);
    lsu_lat = 1;
    g0 = gnt_log.size();
    rq[0].push_back(mk(LSU_LOAD, 64'hA00, 64'h0, 64'h0));
    rq[1].push_back(mk(LSU_LOAD, 64'hB00, 64'h0, 64'h0));
    wait_idle("post_rst", 40);
    if (gnt_log.size() > g0) check("post_rst_first_idx", gnt_log[g0].idx, 0);
    else check("post_rst_grant_seen", gnt_log.size() - g0, 2);
    check("post_rst_cycles", (cyc > c0), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d failures=%0d)", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
